// File: rtl/imem_server.sv
// imem_server: loadable instruction memory with a LOAD/RUN mode FSM.
// In LOAD, a valid/ready loader port writes words into the array. In RUN,
// the fetch port returns registered words with 1-cycle latency.
// Optional feature: define IMEM_ERR_FLAG_EN to add the IMEM_err output.
module imem_server #(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int IMEM_DATA_DEPTH = 1024
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [31:0]                IMEM_addr,
  input  logic                       IMEM_en,
  output logic [31:0]                IMEM_data,
  output logic                       IMEM_ready,
  input  logic                       Load_valid,
  output logic                       Load_ready,
  input  logic [IMEM_ADDR_WIDTH-1:0] Load_addr,
  input  logic [31:0]                Load_data,
  input  logic                       Load_last,
  input  logic                       Load_start,
  output logic [IMEM_ADDR_WIDTH:0]   Load_count
`ifdef IMEM_ERR_FLAG_EN
  ,
  output logic                       IMEM_err
`endif
);

  localparam int                   IDX_W      = (IMEM_DATA_DEPTH > 1) ? $clog2(IMEM_DATA_DEPTH) : 1;
  localparam logic [31:0]          NOP        = 32'h0000_0013;
  localparam logic [32:0]          BYTE_LIMIT = 33'(IMEM_DATA_DEPTH) * 33'd4;
  localparam logic [IMEM_ADDR_WIDTH:0] CNT_MAX = (IMEM_ADDR_WIDTH+1)'(IMEM_DATA_DEPTH);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] mem [IMEM_DATA_DEPTH];

  logic load_fire;
  logic load_in_range;
  logic fetch_bad;

  assign Load_ready    = (state == ST_LOAD);
  assign IMEM_ready    = (state == ST_RUN);
  assign load_fire     = Load_valid & Load_ready;
  assign load_in_range = (33'(Load_addr) < 33'(IMEM_DATA_DEPTH));
  // Misaligned or past the end of the array: the fetch gets a NOP.
  assign fetch_bad     = (IMEM_addr[1:0] != 2'b00) || ({1'b0, IMEM_addr} >= BYTE_LIMIT);

  // Loader writes; the array has no reset so contents survive Reset,
  // but a handshake on a reset edge is dropped because Reset wins.
  always_ff @(posedge Clk) begin
    if (!Reset && load_fire && load_in_range)
      mem[Load_addr[IDX_W-1:0]] <= Load_data;
  end

  // Mode FSM and saturating count of words written since entering LOAD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_LOAD;
      Load_count <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            if (load_in_range && (Load_count != CNT_MAX))
              Load_count <= Load_count + (IMEM_ADDR_WIDTH+1)'(1);
            if (Load_last)
              state <= ST_RUN;
          end
        end
        default: begin
          if (Load_start) begin
            state      <= ST_LOAD;
            Load_count <= '0;
          end
        end
      endcase
    end
  end

  // Fetch register: NOP while loading or leaving RUN, hold when disabled.
  always_ff @(posedge Clk) begin
    if (Reset || (state == ST_LOAD) || Load_start)
      IMEM_data <= NOP;
    else if (IMEM_en)
      IMEM_data <= fetch_bad ? NOP : mem[IMEM_addr[IDX_W+1:2]];
  end

`ifdef IMEM_ERR_FLAG_EN
  // Error flag tracks the same sampled fetch as IMEM_data.
  always_ff @(posedge Clk) begin
    if (Reset || (state == ST_LOAD) || Load_start)
      IMEM_err <= 1'b0;
    else if (IMEM_en)
      IMEM_err <= fetch_bad;
  end
`endif

endmodule
